// File: rtl/dmem_store_buffer_pkg.sv
// Shared types and constants for the data-memory store buffer.
package dmem_store_buffer_pkg;

  localparam int SB_DEPTH_DEF = 4;
  localparam int ADDR_W_DEF   = 32;
  localparam int WIDX_W       = ADDR_W_DEF - 2;

  typedef struct packed {
    logic              valid;
    logic [WIDX_W-1:0] waddr;
    logic [31:0]       wdata;
  } sb_entry_t;

endpackage

// File: rtl/dmem_store_buffer_if.sv
// Memory-stage datapath port plus the RAM read/write port of the store buffer.
interface dmem_store_buffer_if
  import dmem_store_buffer_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) ();

  logic              memwriteM;
  logic              memreadM;
  logic [ADDR_W-1:0] aluoutM;
  logic [31:0]       writedataM;
  logic [31:0]       readdataM;
  logic              stallM;
  logic              sb_empty;
  logic [ADDR_W-3:0] ram_raddr;
  logic [31:0]       ram_rdata;
  logic              ram_we;
  logic [ADDR_W-3:0] ram_waddr;
  logic [31:0]       ram_wdata;
  logic              ram_wready;

  modport slave (
    input  memwriteM, memreadM, aluoutM, writedataM, ram_rdata, ram_wready,
    output readdataM, stallM, sb_empty, ram_raddr, ram_we, ram_waddr, ram_wdata
  );

  modport master (
    output memwriteM, memreadM, aluoutM, writedataM, ram_rdata, ram_wready,
    input  readdataM, stallM, sb_empty, ram_raddr, ram_we, ram_waddr, ram_wdata
  );

endinterface

// File: rtl/dmem_store_buffer_sb_fwd_match.sv
// Youngest-match search over the live store-buffer entries for load forwarding.
module sb_fwd_match
  import dmem_store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH_DEF,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  sb_entry_t         i_entries [DEPTH],
  input  logic [PTR_W-1:0]  i_head,
  input  logic [CNT_W-1:0]  i_count,
  input  logic [WIDX_W-1:0] i_ldWidx,
  output logic              o_hit,
  output logic [31:0]       o_data
);

  logic [PTR_W-1:0] w_idx;

  // Walk from oldest (head) to youngest so the last match seen is the youngest.
  always_comb begin
    o_hit  = 1'b0;
    o_data = '0;
    w_idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_idx = i_head + PTR_W'(i);
      if ((CNT_W'(i) < i_count) && i_entries[w_idx].valid &&
          (i_entries[w_idx].waddr == i_ldWidx)) begin
        o_hit  = 1'b1;
        o_data = i_entries[w_idx].wdata;
      end
    end
  end

endmodule

// File: rtl/dmem_store_buffer.sv
// In-order posted store buffer between the M stage and the data RAM.
module dmem_store_buffer
  import dmem_store_buffer_pkg::*;
#(
  parameter int SB_DEPTH = SB_DEPTH_DEF,
  parameter int ADDR_W   = ADDR_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  dmem_store_buffer_if.slave  bus
);

  localparam int PTR_W = $clog2(SB_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  sb_entry_t         r_entries [SB_DEPTH];
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;

  logic              w_full;
  logic              w_push;
  logic              w_pop;
  logic              w_fwdHit;
  logic [31:0]       w_fwdData;
  logic [WIDX_W-1:0] w_ldWidx;
  logic [1:0]        w_unusedLsb;

  assign w_ldWidx    = bus.aluoutM[ADDR_W-1:2];
  assign w_unusedLsb = bus.aluoutM[1:0];

  // Full is taken from the registered count only, so a same-cycle drain never frees a slot.
  assign w_full = (r_count == CNT_W'(SB_DEPTH));
  assign w_push = bus.memwriteM & ~w_full;
  assign w_pop  = (r_count != '0) & bus.ram_wready;

  assign bus.stallM    = bus.memwriteM & w_full;
  assign bus.sb_empty  = (r_count == '0);
  assign bus.ram_we    = (r_count != '0);
  assign bus.ram_waddr = r_entries[r_head].waddr;
  assign bus.ram_wdata = r_entries[r_head].wdata;
  assign bus.ram_raddr = w_ldWidx;
  assign bus.readdataM = (bus.memreadM && w_fwdHit) ? w_fwdData : bus.ram_rdata;

  sb_fwd_match #(
    .DEPTH (SB_DEPTH)
  ) u_fwd (
    .i_entries (r_entries),
    .i_head    (r_head),
    .i_count   (r_count),
    .i_ldWidx  (w_ldWidx),
    .o_hit     (w_fwdHit),
    .o_data    (w_fwdData)
  );

  // FIFO bookkeeping: enqueue at tail, drain from head, both may happen together.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < SB_DEPTH; i++) begin
        r_entries[i].valid <= 1'b0;
      end
    end else begin
      if (w_push) begin
        r_entries[r_tail] <= '{valid: 1'b1, waddr: w_ldWidx, wdata: bus.writedataM};
        r_tail            <= r_tail + 1'b1;
      end
      if (w_pop) begin
        r_entries[r_head].valid <= 1'b0;
        r_head                  <= r_head + 1'b1;
      end
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Scoreboard bench for dmem_store_buffer: stimulus queues expectations, a monitor checks them.
module tb_dmem_store_buffer;

  localparam int K_WE    = 0;
  localparam int K_EMPTY = 1;
  localparam int K_STALL = 2;
  localparam int K_RADDR = 3;
  localparam int K_WADDR = 4;
  localparam int K_WDATA = 5;

  typedef struct {
    int          kind;
    logic [31:0] exp;
  } stat_t;

  logic clk = 1'b0;
  logic rst;

  logic [31:0] loadQ  [$];
  logic        stallQ [$];
  logic [61:0] wrQ    [$];
  stat_t       statQ  [$];

  int vectors     = 0;
  int miscompares = 0;

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  dmem_store_buffer_if #(.ADDR_W(32)) bus ();

  dmem_store_buffer #(
    .SB_DEPTH (4),
    .ADDR_W   (32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  function automatic string kindName(input int k);
    case (k)
      K_WE:    return "ram_we";
      K_EMPTY: return "sb_empty";
      K_STALL: return "stallM";
      K_RADDR: return "ram_raddr";
      K_WADDR: return "ram_waddr";
      default: return "ram_wdata";
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic we, input logic re, input logic [31:0] addr,
                               input logic [31:0] wd, input logic wready, input logic [31:0] rdata);
    bus.memwriteM  = we;
    bus.memreadM   = re;
    bus.aluoutM    = addr;
    bus.writedataM = wd;
    bus.ram_wready = wready;
    bus.ram_rdata  = rdata;
  endtask

  task automatic expectStat(input int kind, input logic [31:0] val);
    stat_t s;
    s.kind = kind;
    s.exp  = val;
    statQ.push_back(s);
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] data,
                       input logic wready, input logic expStall);
    applyStimulus(1'b1, 1'b0, addr, data, wready, 32'h0);
    stallQ.push_back(expStall);
    if (!expStall) wrQ.push_back({addr[31:2], data});
    tick();
  endtask

  task automatic load(input logic [31:0] addr, input logic [31:0] rdata,
                      input logic wready, input logic [31:0] exp);
    applyStimulus(1'b0, 1'b1, addr, 32'h0, wready, rdata);
    loadQ.push_back(exp);
    tick();
  endtask

  task automatic idle(input logic wready, input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, wready, 32'h0);
      tick();
    end
  endtask

  // Monitor: compares whatever the DUT presents this cycle against the queued expectations.
  always @(negedge clk) begin
    stat_t       s;
    logic [61:0] w;
    logic [31:0] act;
    if (!rst) begin
      if (bus.memreadM) begin
        if (loadQ.size() == 0) checkOutput("unexpected_load", 64'h1, 64'h0);
        else checkOutput("readdataM", 64'(bus.readdataM), 64'(loadQ.pop_front()));
      end
      if (bus.memwriteM) begin
        if (stallQ.size() == 0) checkOutput("unexpected_store", 64'h1, 64'h0);
        else checkOutput("stallM", 64'(bus.stallM), 64'(stallQ.pop_front()));
      end
      if (bus.ram_we && bus.ram_wready) begin
        if (wrQ.size() == 0) begin
          checkOutput("unexpected_write", 64'({bus.ram_waddr, bus.ram_wdata}), 64'h0);
        end else begin
          w = wrQ.pop_front();
          checkOutput("ram_write", 64'({bus.ram_waddr, bus.ram_wdata}), 64'(w));
        end
      end
      while (statQ.size() > 0) begin
        s = statQ.pop_front();
        case (s.kind)
          K_WE:    act = 32'(bus.ram_we);
          K_EMPTY: act = 32'(bus.sb_empty);
          K_STALL: act = 32'(bus.stallM);
          K_RADDR: act = 32'(bus.ram_raddr);
          K_WADDR: act = 32'(bus.ram_waddr);
          default: act = bus.ram_wdata;
        endcase
        checkOutput(kindName(s.kind), 64'(act), 64'(s.exp));
      end
    end
  end

  // Hard time limit so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios with hand-computed expectations.
  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    tick();
    tick();
    rst = 1'b0;

    $display("[TB] reset state");
    expectStat(K_WE, 32'h0);
    expectStat(K_EMPTY, 32'h1);
    expectStat(K_STALL, 32'h0);
    idle(1'b0, 1);

    $display("[TB] forwarding hit");
    store(32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 1'b0);
    expectStat(K_WE, 32'h1);
    expectStat(K_WADDR, 32'h4);
    expectStat(K_WDATA, 32'hDEAD_BEEF);
    load(32'h0000_0010, 32'hAAAA_AAAA, 1'b0, 32'hDEAD_BEEF);
    idle(1'b1, 1);
    expectStat(K_EMPTY, 32'h1);
    idle(1'b0, 1);

    $display("[TB] load miss on empty buffer");
    expectStat(K_RADDR, 32'h10);
    expectStat(K_EMPTY, 32'h1);
    load(32'h0000_0040, 32'h1234_5678, 1'b0, 32'h1234_5678);

    $display("[TB] full buffer stall");
    store(32'h0, 32'hA0, 1'b0, 1'b0);
    store(32'h4, 32'hA1, 1'b0, 1'b0);
    store(32'h8, 32'hA2, 1'b0, 1'b0);
    store(32'hC, 32'hA3, 1'b0, 1'b0);
    store(32'h10, 32'h10, 1'b0, 1'b1);
    store(32'h10, 32'h10, 1'b0, 1'b1);
    store(32'h10, 32'h10, 1'b1, 1'b1);
    store(32'h10, 32'h10, 1'b0, 1'b0);
    load(32'h8, 32'h5555_5555, 1'b0, 32'hA2);
    load(32'h30, 32'h5555_5555, 1'b0, 32'h5555_5555);
    idle(1'b1, 4);
    expectStat(K_EMPTY, 32'h1);
    idle(1'b0, 1);

    $display("[TB] youngest match wins");
    store(32'h20, 32'h1, 1'b0, 1'b0);
    store(32'h22, 32'h2, 1'b0, 1'b0);
    load(32'h20, 32'hFFFF_FFFF, 1'b0, 32'h2);
    idle(1'b1, 2);
    store(32'h50, 32'h77, 1'b0, 1'b0);
    load(32'h50, 32'h0, 1'b1, 32'h77);
    load(32'h50, 32'hCAFE, 1'b0, 32'hCAFE);

    $display("[TB] concurrent enqueue and drain across wrap");
    for (int i = 0; i < 3; i++) store(32'h100 + 32'(i * 4), 32'h4000_0000 + 32'(i), 1'b0, 1'b0);
    for (int i = 3; i < 11; i++) store(32'h100 + 32'(i * 4), 32'h4000_0000 + 32'(i), 1'b1, 1'b0);
    store(32'h100 + 32'(11 * 4), 32'h4000_000B, 1'b0, 1'b0);
    store(32'h100 + 32'(12 * 4), 32'h4000_000C, 1'b0, 1'b1);
    idle(1'b1, 4);

    $display("[TB] reset mid-operation");
    store(32'h60, 32'h600, 1'b0, 1'b0);
    store(32'h64, 32'h601, 1'b0, 1'b0);
    store(32'h68, 32'h602, 1'b0, 1'b0);
    wrQ.delete();
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    tick();
    rst = 1'b0;
    expectStat(K_WE, 32'h0);
    expectStat(K_EMPTY, 32'h1);
    expectStat(K_STALL, 32'h0);
    load(32'h64, 32'hBBBB_BBBB, 1'b0, 32'hBBBB_BBBB);
    store(32'h70, 32'h700, 1'b0, 1'b0);
    idle(1'b1, 6);

    checkOutput("pending_writes", 64'(wrQ.size()), 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dmem_store_buffer.md
Name: dmem_store_buffer

Overview:
- Responder on the memory-stage data interface of the pipelined MIPS datapath. It accepts the address, store data and load/store controls from M, and returns the load word on readdataM in the same cycle.
- Stores are posted into a small in-order FIFO store buffer and drained to the data RAM through a valid/ready write port. Loads are served combinationally from the RAM read port, with store-to-load forwarding from the buffer.
- Raises stallM to the hazard unit when a store arrives and the buffer is full.

Parameters:
- SB_DEPTH, 4: number of store-buffer entries; power of two, at least 2.
- ADDR_W, 32: byte-address width on the datapath side.

Ports:
- clk  in  1  clock; rising edge.
- rst  in  1  synchronous, active-high reset.
- memwriteM  in  1  store in M this cycle.
- memreadM  in  1  load in M this cycle (memtoregM); never high together with memwriteM.
- aluoutM  in  ADDR_W  byte address; bits [1:0] are ignored, word aligned.
- writedataM  in  32  store data.
- readdataM  out  32  load data; combinational.
- stallM  out  1  store not accepted; pipeline must hold F..M.
- sb_empty  out  1  buffer holds no entries.
- ram_raddr  out  ADDR_W-2  word index for the RAM read; equals aluoutM[ADDR_W-1:2].
- ram_rdata  in  32  RAM read data; combinational.
- ram_we  out  1  write request valid.
- ram_waddr  out  ADDR_W-2  word index of the head entry.
- ram_wdata  out  32  data of the head entry.
- ram_wready  in  1  RAM accepts the write this cycle.

Behaviour:
- Clock and reset: single clock clk; rst is synchronous and active-high.
- Storage and reset values:
  - Circular FIFO with head pointer, tail pointer and count (width clog2(SB_DEPTH)+1), plus per-entry valid, word address and data.
  - On reset: pointers = 0, count = 0, all entry valids = 0.
  - Consequently after reset: ram_we = 0, sb_empty = 1, stallM = 0. ram_waddr/ram_wdata are don't-care while ram_we = 0.
- Enqueue:
  - A store is accepted when memwriteM=1 and stallM=0.
  - At the clock edge: write the entry at tail, tail++, count++.
  - Latency from acceptance until the entry is visible to forwarding is 1 cycle.
- Stall:
  - stallM = memwriteM & (count == SB_DEPTH).
  - stallM depends only on registered count, so there is no combinational path from ram_wready.
  - A full buffer stalls even if a drain completes in the same cycle. The store is accepted on the next cycle.
- Drain:
  - ram_we = (count != 0), driven from the head entry.
  - A write transfers when ram_we & ram_wready. At the edge: head++, count--, head valid cleared.
  - ram_waddr/ram_wdata must stay stable while ram_we=1 and ram_wready=0.
- Simultaneous enqueue and drain: count is unchanged and both pointers advance. This is legal at any count < SB_DEPTH.
- Wrap-around: pointers wrap modulo SB_DEPTH; there is no bubble at the wrap.
- Load forwarding:
  - When memreadM=1, compare the word address with every valid entry.
  - If any entry matches, readdataM = data of the youngest match (nearest to tail). Otherwise readdataM = ram_rdata.
  - A store accepted in the same cycle is not forwarded; memreadM and memwriteM are exclusive.
  - An entry draining this cycle still forwards. The RAM is updated only after the edge.
- Loads never stall and never change state.
- When memreadM=0, readdataM = ram_rdata, which is don't-care to the pipeline.
- Reset mid-operation: all buffered stores are discarded and no further ram_we is issued. Software must not depend on stores pending at reset.
- Ordering: RAM writes occur in program order. Multiple stores to the same word all drain; the last one wins.

Decomposition:
- Shared package:
  - SB_DEPTH default.
  - Word-index width constant (ADDR_W-2).
  - Entry struct/typedef {valid, waddr, wdata}.
- Sub-module sb_fwd_match:
  - Combinational youngest-match priority search over the entries.
  - Inputs: entry array, head, count, load word address.
  - Outputs: hit, data.
- The FIFO control stays in the top module.

Test Plan:
1. Forwarding hit:
   - Stimulus: wready=0; store 0x0000_0010 <- 0xDEAD_BEEF; next cycle load 0x10.
   - Required: readdataM = 0xDEADBEEF, ram_we = 1, ram_waddr = 0x4.
2. Full buffer stall:
   - Stimulus: wready=0; 4 stores to 0x0, 0x4, 0x8, 0xC; 5th store to 0x10.
   - Required: stallM = 1 and count stays 4.
   - Then wready=1 for one cycle: count = 3 and stallM still 1 that cycle. The store is accepted on the next cycle with data 0x10.
3. Youngest match wins:
   - Stimulus: wready=0; store 0x20 <- 1, then store 0x22 <- 2 (same word, bits[1:0] ignored); load 0x20.
   - Required: readdataM = 2.
   - After wready=1: RAM sees writes 1 then 2 to word 0x8.
4. Concurrent enqueue and drain:
   - Stimulus: count=3, wready=1, store issued; repeat 8 cycles across the pointer wrap.
   - Required: count stays 3 and drained data follows program order.
5. Load miss:
   - Stimulus: empty buffer, ram_rdata = 0x1234_5678, load 0x40.
   - Required: readdataM = 0x12345678, ram_raddr = 0x10, sb_empty = 1.
6. Reset mid-operation:
   - Stimulus: 3 entries pending, wready=0; assert rst for one cycle.
   - Required: next cycle ram_we = 0, sb_empty = 1, stallM = 0; a load of a previously buffered address returns ram_rdata.
